// File: rtl/rfphoenix_pma_checker_pkg.sv
// +--------------------------------------------------------------------------+
// | rfPhoenixMmupkg: region record, lock words and field/bit indices shared  |
// | by the PMA checker.  Rev 1.0                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package rfPhoenixMmupkg;

   // Address fields are sized for the widest supported AWID; bits above AWID stay zero.
   typedef struct packed {
      logic [63:0] start;
      logic [63:0] nd;
      logic [63:0] pmt;
      logic [63:0] cta;
      logic [19:0] at;
      logic [31:0] lock;
   } REGION;

   localparam logic [31:0] PMA_LOCK = 32'h4C4F434B;
   localparam logic [31:0] PMA_UNLK = 32'h554E4C4B;

   localparam logic [3:0] FLD_START_LO = 4'd0;
   localparam logic [3:0] FLD_START_HI = 4'd1;
   localparam logic [3:0] FLD_ND_LO    = 4'd2;
   localparam logic [3:0] FLD_ND_HI    = 4'd3;
   localparam logic [3:0] FLD_PMT_LO   = 4'd4;
   localparam logic [3:0] FLD_PMT_HI   = 4'd5;
   localparam logic [3:0] FLD_CTA_LO   = 4'd6;
   localparam logic [3:0] FLD_CTA_HI   = 4'd7;
   localparam logic [3:0] FLD_AT       = 4'd8;
   localparam logic [3:0] FLD_HITCNT   = 4'd9;
   localparam logic [3:0] FLD_LOCK     = 4'd14;

   localparam int AT_X     = 0;
   localparam int AT_W     = 1;
   localparam int AT_R     = 2;
   localparam int AT_C     = 3;
   localparam int AT_MT_LO = 8;
   localparam int AT_MT_HI = 11;

   function automatic logic [63:0] wr_word(input logic [63:0] old, input logic [31:0] d,
                                           input logic hi, input logic [63:0] mask);
      return hi ? ({d, old[31:0]} & mask) : ({old[63:32], d} & mask);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rfphoenix_pma_prio_enc.sv
// +--------------------------------------------------------------------------+
// | rfphoenix_pma_prio_enc: highest-index-wins priority encoder. Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module rfphoenix_pma_prio_enc
   import rfPhoenixMmupkg::*;
#(
   parameter int N = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec_i,
   output logic [IW-1:0] index_o,
   output logic          any_o
);

   always_comb begin
      index_o = '0;
      any_o   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec_i[i]) begin
            index_o = IW'(i);
            any_o   = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rfphoenix_pma_checker.sv
// +--------------------------------------------------------------------------+
// | rfphoenix_pma_checker: programmable region table with 2-stage lookup and |
// | permission check. Optional hit counters: RFPHOENIX_PMA_HITCNT_EN. Rev 1.0|
// +--------------------------------------------------------------------------+
`default_nettype none

module rfphoenix_pma_checker
   import rfPhoenixMmupkg::*;
#(
   parameter int          NREGIONS  = 8,
   parameter int          AWID      = 48,
   parameter int          GRAN      = 4,
   parameter logic [63:0] ROM_START = 64'hFFFD0000,
   parameter logic [63:0] ROM_END   = 64'hFFFFFFFF,
   localparam int         RW        = $clog2(NREGIONS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_wr,
   input  logic [RW+3:0]   cfg_adr,
   input  logic [31:0]     cfg_i,
   output logic [31:0]     cfg_o,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [AWID-1:0] req_adr,
   input  logic [2:0]      req_acc,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [RW-1:0]   resp_region_num,
   output REGION           resp_region,
   output logic            resp_nomatch,
   output logic            resp_perm_err
);

   localparam logic [63:0] AMASK   = (64'd1 << AWID) - 64'd1;
   localparam REGION       RGN_RST = '{start: AMASK, nd: AMASK, pmt: '0, cta: '0,
                                       at: '0, lock: PMA_UNLK};
   localparam REGION       RGN_ROM = '{start: ROM_START & AMASK, nd: ROM_END & AMASK,
                                       pmt: '0, cta: '0, at: 20'h0000D, lock: PMA_LOCK};

   REGION            tbl_q [NREGIONS];
   logic [RW-1:0]    cfg_rgn;
   logic [3:0]       cfg_fld;
   REGION            cur_rgn;
   logic             wr_ok;
   logic [31:0]      rd_d, cfg_o_q, hit_rd;

   assign cfg_rgn = cfg_adr[RW+3:4];
   assign cfg_fld = cfg_adr[3:0];
   assign cur_rgn = tbl_q[cfg_rgn];
   assign wr_ok   = cfg_wr && ((cur_rgn.lock == PMA_UNLK) || (cfg_fld == FLD_LOCK));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGIONS; i++) tbl_q[i] <= RGN_RST;
         tbl_q[NREGIONS-1] <= RGN_ROM;
      end else if (wr_ok) begin
         case (cfg_fld)
            FLD_START_LO: tbl_q[cfg_rgn].start <= wr_word(cur_rgn.start, cfg_i, 1'b0, AMASK);
            FLD_START_HI: tbl_q[cfg_rgn].start <= wr_word(cur_rgn.start, cfg_i, 1'b1, AMASK);
            FLD_ND_LO:    tbl_q[cfg_rgn].nd    <= wr_word(cur_rgn.nd,    cfg_i, 1'b0, AMASK);
            FLD_ND_HI:    tbl_q[cfg_rgn].nd    <= wr_word(cur_rgn.nd,    cfg_i, 1'b1, AMASK);
            FLD_PMT_LO:   tbl_q[cfg_rgn].pmt   <= wr_word(cur_rgn.pmt,   cfg_i, 1'b0, AMASK);
            FLD_PMT_HI:   tbl_q[cfg_rgn].pmt   <= wr_word(cur_rgn.pmt,   cfg_i, 1'b1, AMASK);
            FLD_CTA_LO:   tbl_q[cfg_rgn].cta   <= wr_word(cur_rgn.cta,   cfg_i, 1'b0, AMASK);
            FLD_CTA_HI:   tbl_q[cfg_rgn].cta   <= wr_word(cur_rgn.cta,   cfg_i, 1'b1, AMASK);
            FLD_AT:       tbl_q[cfg_rgn].at    <= cfg_i[19:0];
            FLD_LOCK:     tbl_q[cfg_rgn].lock  <= cfg_i;
            default:      ;
         endcase
      end
   end

   // Read mux samples the pre-write table, so a same-cycle write returns the old value.
   always_comb begin
      rd_d = '0;
      case (cfg_fld)
         FLD_START_LO: rd_d = cur_rgn.start[31:0];
         FLD_START_HI: rd_d = cur_rgn.start[63:32];
         FLD_ND_LO:    rd_d = cur_rgn.nd[31:0];
         FLD_ND_HI:    rd_d = cur_rgn.nd[63:32];
         FLD_PMT_LO:   rd_d = cur_rgn.pmt[31:0];
         FLD_PMT_HI:   rd_d = cur_rgn.pmt[63:32];
         FLD_CTA_LO:   rd_d = cur_rgn.cta[31:0];
         FLD_CTA_HI:   rd_d = cur_rgn.cta[63:32];
         FLD_AT:       rd_d = {12'h000, cur_rgn.at};
         FLD_HITCNT:   rd_d = hit_rd;
         FLD_LOCK:     rd_d = cur_rgn.lock;
         default:      rd_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_o_q <= '0;
      else        cfg_o_q <= rd_d;
   end

   logic [NREGIONS-1:0] match;
   logic [RW-1:0]       enc_idx;
   logic                enc_any;
   logic                unused_adr_lsb;

   for (genvar g = 0; g < NREGIONS; g++) begin : g_cmp
      assign match[g] = (req_adr[AWID-1:GRAN] >= tbl_q[g].start[AWID-1:GRAN]) &&
                        (req_adr[AWID-1:GRAN] <= tbl_q[g].nd[AWID-1:GRAN]);
   end
   assign unused_adr_lsb = ^req_adr[GRAN-1:0];

   rfphoenix_pma_prio_enc #(.N(NREGIONS)) u_prio_enc (
      .vec_i   (match),
      .index_o (enc_idx),
      .any_o   (enc_any)
   );

   logic          s1_valid_q, s1_any_q, s2_hold;
   logic [RW-1:0] s1_idx_q;
   logic [2:0]    s1_acc_q;
   REGION         s1_rgn_q;
   logic          resp_valid_q, resp_nomatch_q, resp_perm_err_q;
   logic [RW-1:0] resp_num_q;
   REGION         resp_rgn_q;

   assign s2_hold   = resp_valid_q & ~resp_ready;
   assign req_ready = ~(s1_valid_q & s2_hold);

   // The winning region is captured in stage 1 so later table writes cannot leak into it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q      <= 1'b0;
         s1_any_q        <= 1'b0;
         s1_idx_q        <= '0;
         s1_acc_q        <= '0;
         s1_rgn_q        <= '0;
         resp_valid_q    <= 1'b0;
         resp_nomatch_q  <= 1'b0;
         resp_perm_err_q <= 1'b0;
         resp_num_q      <= '0;
         resp_rgn_q      <= '0;
      end else begin
         if (req_ready) begin
            s1_valid_q <= req_valid;
            if (req_valid) begin
               s1_any_q <= enc_any;
               s1_idx_q <= enc_idx;
               s1_acc_q <= req_acc;
               s1_rgn_q <= tbl_q[enc_idx];
            end
         end
         if (!s2_hold) begin
            resp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               resp_num_q      <= s1_idx_q;
               resp_rgn_q      <= s1_rgn_q;
               resp_nomatch_q  <= ~s1_any_q;
               resp_perm_err_q <= s1_any_q && ((s1_acc_q & s1_rgn_q.at[AT_R:AT_X]) == 3'b000);
            end
         end
      end
   end

`ifdef RFPHOENIX_PMA_HITCNT_EN
   logic [31:0] hit_q [NREGIONS];
   logic        resp_acc;

   assign resp_acc = resp_valid_q & resp_ready & ~resp_nomatch_q;
   assign hit_rd   = hit_q[cfg_rgn];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGIONS; i++) hit_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREGIONS; i++) begin
            if (cfg_wr && (cfg_fld == FLD_HITCNT) && (cfg_rgn == RW'(i)))
               hit_q[i] <= '0;
            else if (resp_acc && (resp_num_q == RW'(i)) && (hit_q[i] != '1))
               hit_q[i] <= hit_q[i] + 32'd1;
         end
      end
   end
`else
   assign hit_rd = '0;
`endif

   assign cfg_o           = cfg_o_q;
   assign resp_valid      = resp_valid_q;
   assign resp_region_num = resp_num_q;
   assign resp_region     = resp_rgn_q;
   assign resp_nomatch    = resp_nomatch_q;
   assign resp_perm_err   = resp_perm_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rfphoenix_pma_checker.sv
// Bench for rfphoenix_pma_checker: directed scenarios plus randomized traffic
// scored against a behavioural region-table model.
`timescale 1ns/1ps
`default_nettype none

module tb_rfphoenix_pma_checker;
   import rfPhoenixMmupkg::*;

   localparam int          NR   = 8;
   localparam int          GR   = 4;
   localparam logic [63:0] MASK = 64'h0000_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_wr;
   logic [6:0]  cfg_adr;
   logic [31:0] cfg_i, cfg_o;
   logic        req_valid, req_ready;
   logic [47:0] req_adr;
   logic [2:0]  req_acc;
   logic        resp_valid, resp_ready;
   logic [2:0]  resp_region_num;
   REGION       resp_region;
   logic        resp_nomatch, resp_perm_err;

   always #5 clk = ~clk;

   rfphoenix_pma_checker dut (
      .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_adr(cfg_adr), .cfg_i(cfg_i),
      .cfg_o(cfg_o), .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
      .req_acc(req_acc), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_region_num(resp_region_num), .resp_region(resp_region),
      .resp_nomatch(resp_nomatch), .resp_perm_err(resp_perm_err)
   );

   typedef struct {
      logic [2:0]  num;
      logic        nomatch;
      logic        perm;
      logic [19:0] at;
      logic [63:0] start;
      logic [31:0] lock;
      int          t;
   } exp_t;

   exp_t        q[$];
   logic [63:0] m_st[NR], m_nd[NR], m_pmt[NR], m_cta[NR];
   logic [19:0] m_at[NR];
   logic [31:0] m_lock[NR], m_hit[NR];
   int          total = 0, bad = 0, cyc = 0, pops = 0;
   bit          last_acc = 0, stall_seen = 0;
   logic [2:0]  last_num;
   logic        last_nomatch, last_perm;

   task automatic model_reset();
      for (int r = 0; r < NR; r++) begin
         m_st[r] = MASK; m_nd[r] = MASK; m_pmt[r] = '0; m_cta[r] = '0;
         m_at[r] = '0; m_lock[r] = PMA_UNLK; m_hit[r] = '0;
      end
      m_st[NR-1] = 64'hFFFD0000; m_nd[NR-1] = 64'hFFFFFFFF;
      m_at[NR-1] = 20'h0000D;    m_lock[NR-1] = PMA_LOCK;
   endtask

   function automatic exp_t model_lookup(input logic [47:0] a, input logic [2:0] acc);
      exp_t e;
      int   hit = -1;
      for (int r = NR - 1; r >= 0 && hit < 0; r--)
         if ((a >> GR) >= (m_st[r][47:0] >> GR) && (a >> GR) <= (m_nd[r][47:0] >> GR)) hit = r;
      if (hit < 0) begin
         e.num = 3'd0; e.nomatch = 1'b1; e.perm = 1'b0; hit = 0;
      end else begin
         e.num = 3'(hit); e.nomatch = 1'b0; e.perm = ((acc & m_at[hit][2:0]) == 3'b000);
      end
      e.at = m_at[hit]; e.start = m_st[hit]; e.lock = m_lock[hit]; e.t = cyc;
      return e;
   endfunction

   function automatic logic [31:0] model_read(input logic [6:0] a);
      int r = int'(a[6:4]);
      case (a[3:0])
         4'd0: return m_st[r][31:0];
         4'd1: return m_st[r][63:32];
         4'd2: return m_nd[r][31:0];
         4'd3: return m_nd[r][63:32];
         4'd4: return m_pmt[r][31:0];
         4'd5: return m_pmt[r][63:32];
         4'd6: return m_cta[r][31:0];
         4'd7: return m_cta[r][63:32];
         4'd8: return {12'h0, m_at[r]};
`ifdef RFPHOENIX_PMA_HITCNT_EN
         4'd9: return m_hit[r];
`endif
         4'd14: return m_lock[r];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_write(input logic [6:0] a, input logic [31:0] d);
      int r = int'(a[6:4]);
      if (a[3:0] == 4'd9) m_hit[r] = '0;
      if (a[3:0] == 4'd14) m_lock[r] = d;
      else if (m_lock[r] == PMA_UNLK) begin
         case (a[3:0])
            4'd0: m_st[r]  = {m_st[r][63:32], d} & MASK;
            4'd1: m_st[r]  = {d, m_st[r][31:0]} & MASK;
            4'd2: m_nd[r]  = {m_nd[r][63:32], d} & MASK;
            4'd3: m_nd[r]  = {d, m_nd[r][31:0]} & MASK;
            4'd4: m_pmt[r] = {m_pmt[r][63:32], d} & MASK;
            4'd5: m_pmt[r] = {d, m_pmt[r][31:0]} & MASK;
            4'd6: m_cta[r] = {m_cta[r][63:32], d} & MASK;
            4'd7: m_cta[r] = {d, m_cta[r][31:0]} & MASK;
            4'd8: m_at[r]  = d[19:0];
            default: ;
         endcase
      end
   endtask

   // One clock: called at a negedge with inputs set; returns at the next negedge.
   task automatic tick();
      logic [31:0] rd_exp;
      bit          exp_rdy, exp_vld;
      exp_t        e;
      #1;
      exp_rdy = !(q.size() == 2 && !resp_ready);
      exp_vld = (q.size() >= 2) || (q.size() == 1 && cyc >= q[0].t + 2);
      total++;
      if (req_ready !== exp_rdy) begin
         bad++; $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy);
      end
      total++;
      if (resp_valid !== exp_vld) begin
         bad++; $display("FAIL resp_valid cyc=%0d got=%b want=%b", cyc, resp_valid, exp_vld);
      end
      if (req_valid && req_ready !== 1'b1) stall_seen = 1;
      rd_exp   = model_read(cfg_adr);
      last_acc = 0;
      if (resp_valid === 1'b1 && resp_ready) begin
         pops++;
         last_num = resp_region_num; last_nomatch = resp_nomatch; last_perm = resp_perm_err;
         total++;
         if (q.size() == 0) begin
            bad++; $display("FAIL unexpected_resp cyc=%0d got num=%0d want none", cyc, resp_region_num);
         end else begin
            e = q.pop_front();
            if ({resp_region_num, resp_nomatch, resp_perm_err, resp_region.at, resp_region.start,
                 resp_region.lock} !== {e.num, e.nomatch, e.perm, e.at, e.start, e.lock}) begin
               bad++;
               $display("FAIL resp cyc=%0d got num=%0d nm=%b pe=%b at=%h st=%h lk=%h want num=%0d nm=%b pe=%b at=%h st=%h lk=%h",
                        cyc, resp_region_num, resp_nomatch, resp_perm_err, resp_region.at,
                        resp_region.start, resp_region.lock, e.num, e.nomatch, e.perm, e.at,
                        e.start, e.lock);
            end
            if (!e.nomatch && m_hit[e.num] != 32'hFFFFFFFF) m_hit[e.num]++;
         end
      end
      if (req_valid && req_ready === 1'b1) begin
         q.push_back(model_lookup(req_adr, req_acc));
         last_acc = 1;
      end
      if (cfg_wr) model_write(cfg_adr, cfg_i);
      @(negedge clk);
      cyc++;
      total++;
      if (cfg_o !== rd_exp) begin
         bad++; $display("FAIL cfg_o cyc=%0d adr=%h got=%h want=%h", cyc, cfg_adr, cfg_o, rd_exp);
      end
   endtask

   task automatic cfgw(input int r, input logic [3:0] f, input logic [31:0] d);
      cfg_wr = 1'b1; cfg_adr = {3'(r), f}; cfg_i = d;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic lookup(input logic [47:0] a, input logic [2:0] acc);
      int p0 = pops, n = 0;
      req_valid = 1'b1; req_adr = a; req_acc = acc; resp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      while (pops == p0 && n < 10) begin tick(); n++; end
      if (pops == p0) begin
         total++; bad++; $display("FAIL lookup_timeout adr=%h got no response want one", a);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_wr = 0; cfg_adr = '0; cfg_i = '0;
      req_valid = 0; req_adr = '0; req_acc = '0; resp_ready = 1'b1;
      @(negedge clk); #1;
      total++;
      if ({resp_valid, resp_nomatch, resp_perm_err, resp_region_num, cfg_o} !== '0) begin
         bad++; $display("FAIL reset_outputs got vld=%b nm=%b pe=%b num=%0d cfg_o=%h want all 0",
                         resp_valid, resp_nomatch, resp_perm_err, resp_region_num, cfg_o);
      end
      model_reset();
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_rom_lookup();
      lookup(48'hFFFE0000, 3'b100);
      total++;
      if ({last_num, last_nomatch, last_perm} !== {3'(NR-1), 1'b0, 1'b0}) begin
         bad++; $display("FAIL rom_read got num=%0d nm=%b pe=%b want num=%0d nm=0 pe=0", last_num, last_nomatch, last_perm, NR-1);
      end
      lookup(48'hFFFE0000, 3'b010);
      total++;
      if (last_perm !== 1'b1) begin bad++; $display("FAIL rom_write_perm got=%b want=1", last_perm); end
      lookup(48'h00001000, 3'b100);
      total++;
      if ({last_num, last_nomatch} !== 4'b0001) begin
         bad++; $display("FAIL nomatch got num=%0d nm=%b want num=0 nm=1", last_num, last_nomatch);
      end
      lookup(48'hFFFD0000, 3'b001);
      total++;
      if ({last_num, last_perm} !== {3'(NR-1), 1'b0}) begin
         bad++; $display("FAIL start_inclusive got num=%0d pe=%b want num=%0d pe=0", last_num, last_perm, NR-1);
      end
      lookup(48'hFFFFFFFF, 3'b100);
      total++;
      if (last_num !== 3'(NR-1)) begin bad++; $display("FAIL end_inclusive got=%0d want=%0d", last_num, NR-1); end
      lookup(48'hFFFCFFFF, 3'b100);
      total++;
      if (last_nomatch !== 1'b1) begin bad++; $display("FAIL below_start got nm=%b want 1", last_nomatch); end
   endtask

   task automatic test_lock();
      cfgw(1, FLD_START_LO, 32'h0);        cfgw(1, FLD_START_HI, 32'h0);
      cfgw(1, FLD_ND_LO, 32'h1FFFFFFF);    cfgw(1, FLD_ND_HI, 32'h0);
      cfgw(1, FLD_AT, 32'h0010F);          cfgw(1, FLD_LOCK, PMA_LOCK);
      cfgw(1, FLD_START_LO, 32'h1000);
      cfg_adr = {3'd1, FLD_START_LO};
      tick();
      total++;
      if (cfg_o !== 32'h0) begin bad++; $display("FAIL locked_write got=%h want=0", cfg_o); end
      lookup(48'h0FFFFFF0, 3'b010);
      total++;
      if ({last_num, last_perm} !== 4'b0010) begin
         bad++; $display("FAIL locked_region got num=%0d pe=%b want num=1 pe=0", last_num, last_perm);
      end
      cfgw(6, FLD_START_LO, 32'h5000); cfgw(6, FLD_START_HI, 32'h0);
      cfgw(6, FLD_ND_LO, 32'h4000);    cfgw(6, FLD_ND_HI, 32'h0);
      cfgw(6, FLD_AT, 32'h7);
      lookup(48'h4800, 3'b100);
      total++;
      if (last_num !== 3'd1) begin bad++; $display("FAIL inverted_region got num=%0d want 1", last_num); end
   endtask

   task automatic test_overlap();
      for (int r = 2; r <= 5; r += 3) begin
         cfgw(r, FLD_START_LO, 32'h100000); cfgw(r, FLD_START_HI, 32'h0);
         cfgw(r, FLD_ND_LO, 32'h1FFFFF);    cfgw(r, FLD_ND_HI, 32'h0);
         cfgw(r, FLD_AT, 32'h7);
      end
      lookup(48'h180000, 3'b100);
      total++;
      if (last_num !== 3'd5) begin bad++; $display("FAIL overlap got num=%0d want 5", last_num); end
      lookup(48'h1FFFFF, 3'b100);
      total++;
      if (last_num !== 3'd5) begin bad++; $display("FAIL overlap_end got num=%0d want 5", last_num); end
      lookup(48'h200000, 3'b100);
      total++;
      if (last_num !== 3'd1) begin bad++; $display("FAIL past_overlap got num=%0d want 1", last_num); end
   endtask

   task automatic test_back_to_back();
      logic [47:0] al[3] = '{48'h0, 48'hFFFE0000, 48'h5};
      int idx = 0, p0 = pops;
      stall_seen = 0;
      for (int c = 0; c < 14; c++) begin
         resp_ready = (c >= 3);
         req_valid  = (idx < 3);
         req_adr    = (idx < 3) ? al[idx] : 48'h0;
         req_acc    = 3'b100;
         tick();
         if (last_acc) idx++;
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      total++;
      if (pops - p0 !== 3 || idx !== 3) begin
         bad++; $display("FAIL b2b_count got accepted=%0d delivered=%0d want 3/3", idx, pops - p0);
      end
      total++;
      if (stall_seen !== 1'b1) begin bad++; $display("FAIL b2b_stall got req_ready never low want low"); end
   endtask

   function automatic logic [47:0] pick_adr();
      int r = $urandom_range(0, NR - 1);
      case ($urandom_range(0, 3))
         0: return m_st[r][47:0] + 48'($urandom_range(0, 32)) - 48'd16;
         1: return m_nd[r][47:0] + 48'($urandom_range(0, 32)) - 48'd16;
         2: return {16'h0, 32'($urandom())};
         default: return 48'hFFFD0000 + 48'($urandom_range(0, 32'h2FFFF));
      endcase
   endfunction

   task automatic test_random();
      logic [3:0] f;
      req_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!req_valid || last_acc) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_adr   = pick_adr();
            req_acc   = 3'(1 << $urandom_range(0, 2));
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         cfg_wr     = ($urandom_range(0, 6) == 0);
         f          = 4'($urandom_range(0, 15));
         cfg_adr    = {3'($urandom_range(0, NR - 1)), f};
         case (f)
            4'd1, 4'd3, 4'd5, 4'd7: cfg_i = 32'($urandom_range(0, 1));
            4'd0, 4'd2:             cfg_i = 32'($urandom()) & 32'h003FFFF0;
            4'd14:                  cfg_i = $urandom_range(0, 1) ? PMA_UNLK : PMA_LOCK;
            default:                cfg_i = 32'($urandom());
         endcase
         tick();
      end
      req_valid = 1'b0; cfg_wr = 1'b0; resp_ready = 1'b1;
      for (int n = 0; n < 10 && q.size() > 0; n++) tick();
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL drain got pending=%0d want 0", q.size()); end
   endtask

   task automatic test_reset_inflight();
      req_valid = 1'b1; resp_ready = 1'b1; req_acc = 3'b100;
      req_adr = 48'hFFFE0000; tick();
      req_adr = 48'h0;        tick();
      req_valid = 1'b0;
      cfg_adr = {3'(NR-1), FLD_HITCNT};
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_flush got vld=%b want 0", resp_valid); end
      total++;
      if (cfg_o !== 32'h0) begin bad++; $display("FAIL reset_cfg_o got=%h want 0", cfg_o); end
      q.delete();
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      for (int n = 0; n < 6; n++) tick();
      total++;
      if (cfg_o !== 32'h0) begin bad++; $display("FAIL hitcnt_after_reset got=%h want 0", cfg_o); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rom_lookup();
      test_lock();
      test_overlap();
      test_back_to_back();
      test_random();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
